// File: rtl/usb_rx_packetizer.sv
// Full-speed USB receive front end: recovers bit timing from oversampled
// D+/D-, NRZI-decodes, strips SYNC and stuffed bits, assembles bytes into
// 32-bit words for the packet buffer and reports each completed packet
// through a held ready/ack handshake.
module usb_rx_packetizer #(
  parameter int BUFFER_SIZE     = 1024,
  parameter int SAMPLES_PER_BIT = 4,
  parameter int ADDRESS_WIDTH   = $clog2(BUFFER_SIZE/4),
  parameter int LENGTH_WIDTH    = $clog2(BUFFER_SIZE)+1
) (
  input  logic                     clk48,
  input  logic                     reset,
  input  logic                     usb_d_p_in,
  input  logic                     usb_d_n_in,
  output logic [ADDRESS_WIDTH-1:0] buffer_write_address,
  output logic [31:0]              buffer_write_value,
  output logic [2:0]               buffer_write_sections,
  output logic                     packet_ready,
  output logic [LENGTH_WIDTH-1:0]  packet_length,
  output logic                     packet_error,
  input  logic                     packet_ack,
  output logic                     receiving
);
  localparam int PHASE_W = $clog2(SAMPLES_PER_BIT) + 1;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_DRAIN, S_DONE, S_HOLD} state_t;

  logic                     dp_meta_q, dp_q, dn_meta_q, dn_q;
  logic [1:0]               line_now, line_prev_q, samp_prev_q;
  logic [PHASE_W-1:0]       phase_q, phase_cur;
  logic                     sample, bit_dec;

  state_t                   state_q, state_d;
  logic [2:0]               zero_cnt_q, zero_cnt_d;
  logic [2:0]               ones_cnt_q, ones_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [1:0]               se0_cnt_q, se0_cnt_d;
  logic [31:0]              word_q, word_d;
  logic [LENGTH_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]              wr_val_q, wr_val_d;
  logic [2:0]               wr_sect_q, wr_sect_d;
  logic [7:0]               new_byte;
  logic [31:0]              word_fill;

  // SE1 is folded into SE0 so only J, K and SE0 reach the decoder
  assign line_now  = (dp_q ^ dn_q) ? {dp_q, dn_q} : LINE_SE0;
  // Any line change realigns the bit window; the bit is taken mid-window
  assign phase_cur = (line_now != line_prev_q) ? '0 : phase_q;
  assign sample    = (phase_cur == PHASE_W'(2));
  assign bit_dec   = (line_now == samp_prev_q);

  // Pad synchronizers, bit-phase tracking and last sampled line state
  always_ff @(posedge clk48) begin
    if (reset) begin
      dp_meta_q   <= 1'b0;
      dp_q        <= 1'b0;
      dn_meta_q   <= 1'b0;
      dn_q        <= 1'b0;
      line_prev_q <= LINE_SE0;
      samp_prev_q <= LINE_SE0;
      phase_q     <= '0;
    end else begin
      dp_meta_q   <= usb_d_p_in;
      dp_q        <= dp_meta_q;
      dn_meta_q   <= usb_d_n_in;
      dn_q        <= dn_meta_q;
      line_prev_q <= line_now;
      phase_q     <= (phase_cur == PHASE_W'(SAMPLES_PER_BIT-1)) ? '0 : phase_cur + PHASE_W'(1);
      if (sample) samp_prev_q <= line_now;
    end
  end

  // Packet state, byte assembly and buffer-write registers
  always_ff @(posedge clk48) begin
    if (reset) begin
      state_q    <= S_IDLE;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      se0_cnt_q  <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_val_q   <= '0;
      wr_sect_q  <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      se0_cnt_q  <= se0_cnt_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      wr_addr_q  <= wr_addr_d;
      wr_val_q   <= wr_val_d;
      wr_sect_q  <= wr_sect_d;
    end
  end

  // Next-state logic: SYNC hunt, unstuffing, byte/word packing, EOP and handshake
  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    se0_cnt_d  = se0_cnt_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    ready_d    = ready_q;
    wr_addr_d  = wr_addr_q;
    wr_val_d   = wr_val_q;
    wr_sect_d  = 3'b000;
    new_byte   = {bit_dec, shift_q[7:1]};
    word_fill  = word_q;
    word_fill[{byte_cnt_q[1:0], 3'b000} +: 8] = new_byte;

    unique case (state_q)
      S_IDLE: begin
        if (sample && line_now == LINE_K && samp_prev_q == LINE_J) begin
          // The J->K edge that wakes us is itself the first SYNC zero
          state_d    = S_SYNC;
          zero_cnt_d = 3'd1;
          bit_cnt_d  = '0;
          se0_cnt_d  = '0;
          word_d     = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_SYNC: begin
        if (sample) begin
          if (line_now == LINE_SE0) begin
            state_d = S_IDLE;
          end else if (!bit_dec) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (zero_cnt_q >= 3'd5) begin
            // The closing 1 of SYNC counts toward the six-ones stuffing run
            state_d    = S_DATA;
            ones_cnt_d = 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          if (line_now == LINE_SE0) begin
            if (se0_cnt_q != 2'd2) se0_cnt_d = se0_cnt_q + 2'd1;
          end else if (se0_cnt_q != 2'd0) begin
            if (se0_cnt_q == 2'd2 && line_now == LINE_J) begin
              state_d = S_DONE;
            end else begin
              err_d     = 1'b1;
              se0_cnt_d = '0;
              state_d   = S_DRAIN;
            end
          end else if (ones_cnt_q == 3'd6) begin
            ones_cnt_d = '0;
            if (bit_dec) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            ones_cnt_d = bit_dec ? ones_cnt_q + 3'd1 : 3'd0;
            shift_d    = new_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == LENGTH_WIDTH'(BUFFER_SIZE)) begin
                err_d = 1'b1;
              end else begin
                byte_cnt_d = byte_cnt_q + LENGTH_WIDTH'(1);
                word_d     = word_fill;
                if (byte_cnt_q[1:0] == 2'd3) begin
                  wr_sect_d = 3'b111;
                  wr_val_d  = word_fill;
                  wr_addr_d = byte_cnt_q[ADDRESS_WIDTH+1:2];
                  word_d    = '0;
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (sample) begin
          if (line_now == LINE_SE0) se0_cnt_d = 2'd1;
          else if (line_now == LINE_J && se0_cnt_q != 2'd0) state_d = S_DONE;
          else se0_cnt_d = '0;
        end
      end
      S_DONE: begin
        // A packet abandoned on a stuffing violation leaves its partial word unwritten
        if (!err_q && byte_cnt_q[1:0] != 2'd0) begin
          wr_sect_d = 3'b111;
          wr_val_d  = word_q;
          wr_addr_d = byte_cnt_q[ADDRESS_WIDTH+1:2];
        end
        if (bit_cnt_q != 3'd0) err_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ready_q) begin
          if (packet_ack) ready_d = 1'b0;
        end else if (line_now == LINE_J) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign buffer_write_address  = wr_addr_q;
  assign buffer_write_value    = wr_val_q;
  assign buffer_write_sections = wr_sect_q;
  assign packet_ready          = ready_q;
  assign packet_length         = byte_cnt_q;
  assign packet_error          = err_q;
  assign receiving             = (state_q == S_SYNC) || (state_q == S_DATA);
endmodule

// File: doc/usb_rx_packetizer.md
Name: usb_rx_packetizer

Overview:
- Full-speed USB (12 Mbit/s) receive front end in the clk48 domain.
- Recovers bit timing from the D+/D- lines at 4x oversampling, then performs NRZI decode, SYNC detect, bit unstuffing, byte assembly and EOP detect.
- Writes packet bytes as 32-bit words into the USB packet buffer through its `write_sections` port.
- Signals packet completion to the CPU side with a held ready/ack handshake.
- Sits between the USB pads and the USB packet buffer, directly upstream of the buffer's write port.

Parameters:
- BUFFER_SIZE, 1024: packet buffer capacity in bytes; must be a multiple of 4.
- SAMPLES_PER_BIT, 4: clk48 cycles per USB bit.
- ADDRESS_WIDTH, $clog2(BUFFER_SIZE/4): word address width (8 at default).
- LENGTH_WIDTH, $clog2(BUFFER_SIZE)+1: byte count width (11 at default).

Ports:
- clk48  in  1  48 MHz clock; the only clock.
- reset  in  1  synchronous, active-high.
- usb_d_p_in  in  1  raw D+ input; synchronized internally with 2 flops.
- usb_d_n_in  in  1  raw D- input; synchronized internally with 2 flops.
- buffer_write_address  out  ADDRESS_WIDTH  word index into the packet buffer.
- buffer_write_value  out  32  word data; byte n of the packet sits in lane n%4 (lane 0 = bits 7:0).
- buffer_write_sections  out  3  bit0 = [7:0], bit1 = [15:8], bit2 = [31:16]; either 3'b000 or 3'b111.
- packet_ready  out  1  a completed packet is in the buffer.
- packet_length  out  LENGTH_WIDTH  byte count of the packet; valid while packet_ready=1.
- packet_error  out  1  packet was bad; valid while packet_ready=1.
- packet_ack  in  1  consumer releases the packet.
- receiving  out  1  high while in SYNC or DATA.

Behaviour:
- Clock and reset:
  - Single clock clk48.
  - reset is synchronous and active-high.
  - On reset: all outputs 0, state IDLE, counters 0.
- Line states (after synchronizer):
  - J = (1,0); K = (0,1); SE0 = (0,0); SE1 = (1,1), which is treated as SE0.
- Bit timing:
  - A phase counter runs 0..SAMPLES_PER_BIT-1.
  - It is cleared to 0 on every J/K change.
  - The line is sampled as a bit when phase == 2.
  - Tolerates ±1 cycle of edge jitter.
- NRZI: decoded bit = 1 if the sampled state equals the previous sampled state, else 0.
- State machine:
  - IDLE: on K after J -> SYNC.
  - SYNC: counts decoded 0s.
    - Decoded 1 after at least 5 consecutive 0s -> DATA.
    - Decoded 1 earlier -> IDLE.
    - SE0 -> IDLE.
  - DATA: bits are shifted in LSB first; every 8 unstuffed bits form one byte.
    - Stuffing: after 6 consecutive decoded 1s the next bit is discarded; a 0 is expected.
    - If that bit is 1 -> set error, go to DRAIN.
    - Two consecutive SE0 bit samples followed by J -> DONE.
  - DRAIN: wait for SE0 then J -> DONE. No buffer writes occur in DRAIN.
  - DONE:
    - If an assembled word is partial, flush it: unfilled lanes 0, sections 111.
    - Set packet_error if bit count mod 8 ≠ 0 at EOP.
    - Next cycle -> HOLD with packet_ready=1.
  - HOLD:
    - packet_ready, packet_length and packet_error are stable.
    - The line is ignored; packets arriving during HOLD are dropped entirely.
    - On packet_ack=1 -> packet_ready=0 next cycle, enter IDLE only once the line is J.
    - packet_ack is ignored outside HOLD.
- Buffer writes:
  - Byte k goes to word k>>2, lane k&3.
  - A full word is written (sections 111) in the cycle after lane 3 fills; sections are 000 in all other cycles.
  - buffer_write_address = (k>>2) mod (BUFFER_SIZE/4).
  - Every packet starts at address 0.
  - Zero-length packets (SYNC then EOP) produce no write and length 0.
- Overflow: a byte arriving when byte_count == BUFFER_SIZE sets the error and suppresses all further writes; length saturates at BUFFER_SIZE.
- Reset mid-packet: the packet is abandoned, with no ready and no further writes.

Test Plan:
1. Good packet:
   - Stimulus: SYNC, bytes 0x2D 0x00 0x10, EOP.
   - Response: exactly one write, address 0, value 0x0010002D, sections 111; packet_ready=1, length 3, error 0.
2. Bit stuffing:
   - Stimulus: bytes 0xFF 0xFF 0x01 0x02 0x03 with correct stuffed bits.
   - Response: word0 = 0x0201FFFF, word1 = 0x00000003; length 5; error 0.
3. Stuff error:
   - Stimulus: seven undecoded consecutive 1s inside byte 1.
   - Response: error 1 after EOP, packet_ready=1, no write after the violation.
4. Hold and ack:
   - Stimulus: a second packet sent while packet_ready=1.
   - Response: no writes, length unchanged.
   - Then: after packet_ack, a third packet 0xA5 gives a write of 0x000000A5 at address 0 and length 1.
5. Reset mid-packet:
   - Stimulus: reset asserted after 2 data bytes.
   - Response: all outputs 0 next cycle, no ready, next packet decodes normally.
6. Jitter:
   - Stimulus: transitions alternately shifted ±1 clk48 cycle over a 4-byte packet 0x11223344.
   - Response: write value 0x44332211 (bytes in wire order 0x11, 0x22, 0x33, 0x44), error 0.
